// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and an opcode byte from the UART receiver, runs them through the ALU and hands the result to the transmitter.
// Latency: opcode tick at t -> o_alu_op at t+1, o_tx_start at t+2; bytes arriving while a result is in flight are dropped and flagged on o_overrun.
module uart_alu_sequencer #(
  parameter int                    NB_DATA    = 8,
  parameter int                    NB_OP      = 6,
  parameter int                    NB_TIMEOUT = 20,
  parameter logic [NB_TIMEOUT-1:0] TIMEOUT    = 20'd1_000_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  localparam logic [NB_TIMEOUT-1:0] TMO_LAST = TIMEOUT - NB_TIMEOUT'(1);

  state_t                state, state_next;
  logic [NB_TIMEOUT-1:0] tmo_cnt, tmo_cnt_next;
  logic [NB_DATA-1:0]    alu_a_next, alu_b_next, tx_data_next;
  logic [NB_OP-1:0]      alu_op_next;
  logic                  tx_start_next, op_error_next, timeout_next, overrun_next;
  logic                  op_valid;
  logic                  tmo_expired;

  // Opcode byte is legal only with its spare upper bits clear.
  always_comb begin
    op_valid = 1'b0;
    if ((i_rx_data >> NB_OP) == '0) begin
      case (i_rx_data[NB_OP-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
        default:                        op_valid = 1'b0;
      endcase
    end
  end

  assign tmo_expired = (tmo_cnt == TMO_LAST);
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    tmo_cnt_next  = tmo_cnt;
    alu_a_next    = o_alu_a;
    alu_b_next    = o_alu_b;
    alu_op_next   = o_alu_op;
    tx_data_next  = o_tx_data;
    tx_start_next = 1'b0;
    op_error_next = 1'b0;
    timeout_next  = 1'b0;
    overrun_next  = 1'b0;

    case (state)
      IDLE: begin
        if (i_rx_done_tick) begin
          alu_a_next   = i_rx_data;
          tmo_cnt_next = '0;
          state_next   = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done_tick) begin
          alu_b_next   = i_rx_data;
          tmo_cnt_next = '0;
          state_next   = WAIT_OP;
        end else if (tmo_expired) begin
          timeout_next = 1'b1;
          tmo_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + NB_TIMEOUT'(1);
        end
      end
      WAIT_OP: begin
        if (i_rx_done_tick) begin
          tmo_cnt_next = '0;
          if (op_valid) begin
            alu_op_next = i_rx_data[NB_OP-1:0];
            state_next  = EXEC;
          end else begin
            op_error_next = 1'b1;
            state_next    = IDLE;
          end
        end else if (tmo_expired) begin
          timeout_next = 1'b1;
          tmo_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + NB_TIMEOUT'(1);
        end
      end
      EXEC: begin
        tx_data_next  = i_alu_result;
        tx_start_next = 1'b1;
        overrun_next  = i_rx_done_tick;
        state_next    = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_next = i_rx_done_tick;
        if (i_tx_done_tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        tmo_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tmo_cnt    <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_op_error <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      tmo_cnt    <= tmo_cnt_next;
      o_alu_a    <= alu_a_next;
      o_alu_b    <= alu_b_next;
      o_alu_op   <= alu_op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= tx_start_next;
      o_op_error <= op_error_next;
      o_timeout  <= timeout_next;
      o_overrun  <= overrun_next;
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: frame-level reference model compared every cycle, plus directed frames with literal results.
module tb_uart_alu_sequencer;

  localparam int TO = 16;

  logic       i_clock;
  logic       i_reset;
  logic       i_rx_done_tick;
  logic [7:0] i_rx_data;
  logic       i_tx_done_tick;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_op_error, o_timeout, o_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  uart_alu_sequencer #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(20), .TIMEOUT(20'd16)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .i_tx_done_tick(i_tx_done_tick), .i_alu_result(i_alu_result),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
    .o_op_error(o_op_error), .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic bit is_op(input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (valid_ops[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  assign i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many bytes of the current frame are held,
  // whether a result is about to be produced or awaiting the transmitter,
  // and how long the frame has been silent.
  int         m_have  = 0;
  bit         m_exec  = 0;
  bit         m_txw   = 0;
  int         m_gap   = 0;
  logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
  logic [5:0] m_op = 0;
  bit         m_start = 0, m_operr = 0, m_to = 0, m_ovr = 0;

  always @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      m_have <= 0; m_exec <= 0; m_txw <= 0; m_gap <= 0;
      m_a <= 0; m_b <= 0; m_op <= 0; m_txd <= 0;
      m_start <= 0; m_operr <= 0; m_to <= 0; m_ovr <= 0;
    end else begin
      m_start <= 0; m_operr <= 0; m_to <= 0; m_ovr <= 0;
      if (m_exec) begin
        m_txd   <= alu(m_a, m_b, m_op);
        m_start <= 1;
        m_exec  <= 0;
        m_txw   <= 1;
        m_ovr   <= i_rx_done_tick;
      end else if (m_txw) begin
        m_ovr <= i_rx_done_tick;
        if (i_tx_done_tick) m_txw <= 0;
      end else if (i_rx_done_tick) begin
        m_gap <= 0;
        if (m_have == 0) begin
          m_a <= i_rx_data; m_have <= 1;
        end else if (m_have == 1) begin
          m_b <= i_rx_data; m_have <= 2;
        end else begin
          m_have <= 0;
          if (is_op(i_rx_data)) begin
            m_op <= i_rx_data[5:0]; m_exec <= 1;
          end else begin
            m_operr <= 1;
          end
        end
      end else if (m_have > 0) begin
        if (m_gap == TO - 1) begin
          m_to <= 1; m_have <= 0; m_gap <= 0;
        end else begin
          m_gap <= m_gap + 1;
        end
      end
    end
  end

  always @(negedge i_clock) begin
    chk("alu_a",    32'(o_alu_a),    32'(m_a));
    chk("alu_b",    32'(o_alu_b),    32'(m_b));
    chk("alu_op",   32'(o_alu_op),   32'(m_op));
    chk("tx_data",  32'(o_tx_data),  32'(m_txd));
    chk("tx_start", 32'(o_tx_start), 32'(m_start));
    chk("busy",     32'(o_busy),     32'(m_have > 0 || m_exec || m_txw));
    chk("op_error", 32'(o_op_error), 32'(m_operr));
    chk("timeout",  32'(o_timeout),  32'(m_to));
    chk("overrun",  32'(o_overrun),  32'(m_ovr));
  end

  task automatic cycle(input logic rx, input logic [7:0] d, input logic tx);
    i_rx_done_tick = rx;
    i_rx_data      = d;
    i_tx_done_tick = tx;
    @(posedge i_clock);
    #1;
    i_rx_done_tick = 1'b0;
    i_tx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  logic       r_rx, r_tx;
  logic [7:0] r_d;
  int         rx_div;

  initial begin
    i_reset = 1'b0; i_rx_done_tick = 1'b0; i_rx_data = 8'h00; i_tx_done_tick = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset outputs", 32'({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start}), 32'd0);
    i_reset = 1'b1;
    idle(2);

    // ADD frame with exact start latency
    cycle(1'b1, 8'h05, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    cycle(1'b1, 8'h20, 1'b0);
    chk("add op at t+1", 32'(o_alu_op), 32'h20);
    chk("add no start at t+1", 32'(o_tx_start), 32'd0);
    idle(1);
    chk("add start at t+2", 32'(o_tx_start), 32'd1);
    chk("add result", 32'(o_tx_data), 32'h08);
    chk("model add result", 32'(m_txd), 32'h08);
    idle(1);
    chk("add start once", 32'(o_tx_start), 32'd0);
    chk("add busy in wait_tx", 32'(o_busy), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("add idle after tx_done", 32'(o_busy), 32'd0);

    // SRA frame
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    idle(1);
    chk("sra result", 32'(o_tx_data), 32'hFC);
    chk("model sra result", 32'(m_txd), 32'hFC);
    cycle(1'b0, 8'h00, 1'b1);

    // Bad opcode
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h3F, 1'b0);
    chk("op_error pulse", 32'(o_op_error), 32'd1);
    chk("op_error busy", 32'(o_busy), 32'd0);
    chk("op_error op held", 32'(o_alu_op), 32'h03);
    idle(1);
    chk("op_error once", 32'(o_op_error), 32'd0);
    chk("op_error no start", 32'(o_tx_start), 32'd0);
    idle(2);

    // Timeout after 16 silent cycles
    cycle(1'b1, 8'h01, 1'b0);
    idle(TO - 1);
    chk("timeout not early", 32'(o_timeout), 32'd0);
    idle(1);
    chk("timeout pulse", 32'(o_timeout), 32'd1);
    chk("model timeout", 32'(m_to), 32'd1);
    chk("timeout busy", 32'(o_busy), 32'd0);
    cycle(1'b1, 8'h77, 1'b0);
    chk("after timeout loads a", 32'(o_alu_a), 32'h77);
    // Byte on the limit cycle wins over the timeout
    idle(TO - 1);
    cycle(1'b1, 8'h44, 1'b0);
    chk("limit tick no timeout", 32'(o_timeout), 32'd0);
    chk("limit tick loads b", 32'(o_alu_b), 32'h44);
    cycle(1'b1, 8'h25, 1'b0);
    idle(1);
    chk("or result", 32'(o_tx_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b1);

    // Overrun during WAIT_TX
    cycle(1'b1, 8'h0F, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b1, 8'h24, 1'b0);
    idle(1);
    chk("and result", 32'(o_tx_data), 32'h03);
    cycle(1'b1, 8'hAA, 1'b0);
    chk("overrun pulse", 32'(o_overrun), 32'd1);
    chk("overrun data held", 32'(o_tx_data), 32'h03);
    chk("overrun a held", 32'(o_alu_a), 32'h0F);
    idle(1);
    chk("overrun once", 32'(o_overrun), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("overrun completes", 32'(o_busy), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("tx_done in idle ignored", 32'(o_busy | o_tx_start), 32'd0);

    // Asynchronous reset in WAIT_OP
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    chk("pre-reset b", 32'(o_alu_b), 32'h22);
    #2;
    i_reset = 1'b0;
    #1;
    chk("async reset outputs",
        32'({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start}), 32'd0);
    chk("async reset flags",
        32'({o_busy, o_op_error, o_timeout, o_overrun}), 32'd0);
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    cycle(1'b1, 8'h09, 1'b0);
    chk("post-reset a", 32'(o_alu_a), 32'h09);
    cycle(1'b1, 8'h04, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    idle(1);
    chk("post-reset sub", 32'(o_tx_data), 32'h05);
    chk("post-reset start", 32'(o_tx_start), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic, segments of differing byte density
    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(2))
        0:       rx_div = 2;
        1:       rx_div = 4;
        default: rx_div = 14;
      endcase
      for (int c = 0; c < 250; c++) begin
        r_rx = ($urandom_range(rx_div - 1) == 0);
        r_tx = ($urandom_range(4) == 0);
        if ($urandom_range(1) == 0) r_d = valid_ops[$urandom_range(7)];
        else                        r_d = 8'($urandom);
        cycle(r_rx, r_d, r_tx);
      end
    end

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8: width of UART data bytes, operands and result.
REQ-002 Parameter NB_OP, default 6: width of the ALU opcode.
REQ-003 Parameter NB_TIMEOUT, default 20: width of the inter-byte timeout counter.
REQ-004 Parameter TIMEOUT, default 20'd1_000_000: number of clock cycles allowed between consecutive bytes of one frame.
REQ-005 i_clock  input  1  single system clock; all state updates occur on its rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 i_rx_done_tick  input  1  one-cycle pulse; a received byte is valid on i_rx_data.
REQ-008 i_rx_data  input  NB_DATA  received byte, sampled only when i_rx_done_tick=1.
REQ-009 i_tx_done_tick  input  1  one-cycle pulse; the transmitter has finished its byte.
REQ-010 i_alu_result  input  NB_DATA  combinational ALU result for o_alu_a, o_alu_b and o_alu_op.
REQ-011 o_alu_a, o_alu_b  output  NB_DATA each  registered ALU operands.
REQ-012 o_alu_op  output  NB_OP  registered ALU opcode.
REQ-013 o_tx_start  output  1  one-cycle request to transmit o_tx_data.
REQ-014 o_tx_data  output  NB_DATA  registered result byte for the transmitter.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_op_error, o_timeout, o_overrun  output  1 each  one-cycle error pulses.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_B, WAIT_OP, EXEC and WAIT_TX, encoded in 3 bits; undefined encodings go to IDLE on the next edge.
REQ-018 IDLE: on i_rx_done_tick, load o_alu_a with i_rx_data, clear the timeout counter and go to WAIT_B.
REQ-019 WAIT_B: on i_rx_done_tick, load o_alu_b, clear the timeout counter and go to WAIT_OP.
REQ-020 WAIT_OP: on i_rx_done_tick with a valid opcode byte, load o_alu_op with i_rx_data[NB_OP-1:0] and go to EXEC.
REQ-021 A valid opcode byte has its upper NB_DATA-NB_OP bits at zero and its low bits equal to one of: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
REQ-022 An invalid opcode byte in WAIT_OP pulses o_op_error for one cycle, leaves o_alu_op unchanged and returns the FSM to IDLE.
REQ-023 EXEC lasts exactly one cycle: capture i_alu_result into o_tx_data, assert o_tx_start in the following cycle only, and go to WAIT_TX.
REQ-024 Latency: an opcode tick at cycle t gives o_alu_op valid at t+1 and o_tx_start=1 at t+2 only.
REQ-025 WAIT_TX: hold o_tx_data stable; on i_tx_done_tick go to IDLE.
REQ-026 In WAIT_B and WAIT_OP, the timeout counter increments each cycle without an rx tick.
REQ-027 When the timeout counter reaches TIMEOUT-1 without an rx tick, pulse o_timeout, return to IDLE and discard the partial frame.
REQ-028 An rx tick on the same cycle as the timeout limit takes priority: the byte is accepted and o_timeout stays 0.
REQ-029 An i_rx_done_tick in EXEC or WAIT_TX is dropped, pulses o_overrun for one cycle, and leaves the state and registers unchanged.
REQ-030 An i_tx_done_tick outside WAIT_TX is ignored.
REQ-031 o_alu_a, o_alu_b and o_alu_op change only as defined in REQ-018 to REQ-020, and are held otherwise, including after errors.

Reset
REQ-032 While i_reset=0, immediately and independently of i_clock: state=IDLE, timeout counter=0, and all outputs = 0.
REQ-033 Reset asserted mid-frame or during WAIT_TX aborts the frame; no o_tx_start follows.
REQ-034 After i_reset deasserts, the first i_rx_done_tick is treated as operand A.

Verification
REQ-035 Send bytes 0x05, 0x03, 0x20 with an ALU model -> o_alu_op=6'b100000, o_tx_start pulses once at t+2, o_tx_data=0x08, FSM in IDLE after i_tx_done_tick.
REQ-036 Send bytes 0xF0, 0x02, 0x03 (SRA) -> o_tx_data=0xFC.
REQ-037 Send bytes 0x01, 0x02, 0x3F -> o_op_error pulses once, no o_tx_start, o_busy=0 on the next cycle.
REQ-038 TIMEOUT=16; send 0x01, then no byte for 16 cycles -> o_timeout pulses, FSM in IDLE; the next byte loads o_alu_a.
REQ-039 Inject an rx tick during WAIT_TX -> o_overrun pulses, o_tx_data unchanged, the FSM still completes on i_tx_done_tick.
REQ-040 Drive i_reset=0 asynchronously in WAIT_OP -> all outputs are 0 before the next clock edge; a full frame after release works.
